// File: rtl/syscall_sequencer.sv
// syscall_sequencer: run/pause/wait/halt control for syscall-driven display and stop; define CYCLE_COUNT_EN to build the retired-instruction counter.
module syscall_sequencer #(
  parameter int unsigned PAUSE_CYCLES = 8
) (
  input  logic        in_clk,
  input  logic        in_rst,
  input  logic        in_instr_valid,
  input  logic        in_syscall,
  input  logic [31:0] in_v0,
  input  logic [31:0] in_a0,
  input  logic        in_go,
  output logic        out_pc_en,
  output logic        out_halted,
  output logic [31:0] out_disp,
  output logic        out_disp_valid,
  output logic [31:0] out_cycles
);
  typedef enum logic [1:0] {RUN, PAUSE, WAIT_GO, HALT} state_t;
  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [31:0] disp_q, disp_d;
  logic        disp_valid_q, disp_valid_d;
  logic        go_q;
  logic        ev, go_edge;
  assign ev      = in_syscall && in_instr_valid && state_q == RUN;
  assign go_edge = in_go && !go_q;
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    disp_d       = disp_q;
    disp_valid_d = 1'b0;
    case (state_q)
      RUN: if (ev) begin
        if (in_v0 == 32'd10) state_d = HALT;
        else if (in_v0 == 32'd50) state_d = WAIT_GO;
        else if (in_v0 == 32'd34) begin
          state_d      = PAUSE;
          disp_d       = in_a0;
          disp_valid_d = 1'b1;
          cnt_d        = 16'(PAUSE_CYCLES - 1);
        end
      end
      PAUSE: begin
        state_d = cnt_q == 16'd0 ? RUN : PAUSE;
        cnt_d   = cnt_q == 16'd0 ? cnt_q : cnt_q - 16'd1;
      end
      default: state_d = go_edge ? RUN : state_q;
    endcase
  end
  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      state_q      <= RUN;
      cnt_q        <= '0;
      disp_q       <= '0;
      disp_valid_q <= 1'b0;
      go_q         <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      disp_q       <= disp_d;
      disp_valid_q <= disp_valid_d;
      go_q         <= in_go;
    end
  end
  assign out_pc_en      = state_q == RUN;
  assign out_halted     = state_q == HALT;
  assign out_disp       = disp_q;
  assign out_disp_valid = disp_valid_q;
`ifdef CYCLE_COUNT_EN
  logic [31:0] cycles_q, cycles_d;
  assign cycles_d = cycles_q + 32'(out_pc_en && in_instr_valid);
  always_ff @(posedge in_clk) begin
    if (in_rst) cycles_q <= '0;
    else cycles_q <= cycles_d;
  end
  assign out_cycles = cycles_q;
`else
  assign out_cycles = '0;
`endif
endmodule

// File: tb/tb_syscall_sequencer.sv
// tb_syscall_sequencer: directed scenarios plus randomized run against a stall/wait/halt reference model.
module tb_syscall_sequencer;
  localparam int P = 8;
  logic        in_clk = 0, in_rst = 0, in_instr_valid = 0, in_syscall = 0, in_go = 0;
  logic [31:0] in_v0 = 0, in_a0 = 0;
  logic        out_pc_en, out_halted, out_disp_valid;
  logic [31:0] out_disp, out_cycles;
  int checks = 0, failures = 0;

  syscall_sequencer #(.PAUSE_CYCLES(P)) dut (
    .in_clk(in_clk), .in_rst(in_rst), .in_instr_valid(in_instr_valid),
    .in_syscall(in_syscall), .in_v0(in_v0), .in_a0(in_a0), .in_go(in_go),
    .out_pc_en(out_pc_en), .out_halted(out_halted), .out_disp(out_disp),
    .out_disp_valid(out_disp_valid), .out_cycles(out_cycles)
  );

  always #5 in_clk = ~in_clk;

  // Reference model: remaining stall cycles plus "blocked until go" flags.
  int          m_stall;
  bit          m_wait, m_halt, m_pgo, m_dv, m_run;
  logic [31:0] m_disp, m_cyc;
  always @(posedge in_clk) begin
    if (in_rst) begin
      m_stall = 0; m_wait = 0; m_halt = 0; m_pgo = 0; m_dv = 0;
      m_disp = 0; m_cyc = 0;
    end else begin
      m_run = m_stall == 0 && !m_wait && !m_halt;
      m_dv = 0;
`ifdef CYCLE_COUNT_EN
      if (m_run && in_instr_valid) m_cyc = m_cyc + 1;
`endif
      if (m_stall > 0) m_stall = m_stall - 1;
      else if ((m_wait || m_halt) && in_go && !m_pgo) begin m_wait = 0; m_halt = 0; end
      else if (m_run && in_instr_valid && in_syscall) begin
        if (in_v0 == 10) m_halt = 1;
        else if (in_v0 == 50) m_wait = 1;
        else if (in_v0 == 34) begin m_disp = in_a0; m_dv = 1; m_stall = P; end
      end
      m_pgo = in_go;
    end
  end

  task automatic tick(); @(negedge in_clk); endtask

  task automatic do_reset();
    in_rst = 1; in_instr_valid = 0; in_syscall = 0; in_go = 0;
    tick(); in_rst = 0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (out_pc_en !== 1'b1) begin failures++; $display("FAIL reset_pc_en got=%b exp=1", out_pc_en); end
    checks++; if (out_halted !== 1'b0) begin failures++; $display("FAIL reset_halted got=%b exp=0", out_halted); end
    checks++; if (out_disp !== 32'd0) begin failures++; $display("FAIL reset_disp got=%h exp=0", out_disp); end
    checks++; if (out_disp_valid !== 1'b0) begin failures++; $display("FAIL reset_dv got=%b exp=0", out_disp_valid); end
    checks++; if (out_cycles !== 32'd0) begin failures++; $display("FAIL reset_cycles got=%h exp=0", out_cycles); end
  endtask

  task automatic test_count();
    logic [31:0] exp;
`ifdef CYCLE_COUNT_EN
    exp = 5;
`else
    exp = 0;
`endif
    in_instr_valid = 1; in_syscall = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (out_pc_en !== 1'b1) begin failures++; $display("FAIL count_pc_en cyc=%0d got=%b exp=1", i, out_pc_en); end
    end
    in_instr_valid = 0;
    checks++; if (out_cycles !== exp) begin failures++; $display("FAIL count_cycles got=%0d exp=%0d", out_cycles, exp); end
  endtask

  task automatic test_display();
    int n;
    in_instr_valid = 1; in_syscall = 1; in_v0 = 34; in_a0 = 32'hDEADBEEF;
    checks++; if (out_pc_en !== 1'b1) begin failures++; $display("FAIL disp_event_pc_en got=%b exp=1", out_pc_en); end
    tick();
    in_syscall = 0; in_a0 = 0;
    checks++; if (out_disp !== 32'hDEADBEEF) begin failures++; $display("FAIL disp_value got=%h exp=deadbeef", out_disp); end
    checks++; if (out_disp_valid !== 1'b1) begin failures++; $display("FAIL disp_valid_pulse got=%b exp=1", out_disp_valid); end
    n = 0;
    while (out_pc_en === 1'b0 && n < 40) begin
      n++;
      in_syscall = (n == 3); in_v0 = 34;
      in_go = (n >= 2 && n < 4);
      tick();
      if (n == 1) begin
        checks++; if (out_disp_valid !== 1'b0) begin failures++; $display("FAIL disp_valid_width got=%b exp=0", out_disp_valid); end
      end
    end
    in_syscall = 0; in_go = 0;
    checks++; if (n !== P) begin failures++; $display("FAIL pause_len got=%0d exp=%0d", n, P); end
    checks++; if (out_disp !== 32'hDEADBEEF) begin failures++; $display("FAIL disp_hold got=%h exp=deadbeef", out_disp); end
  endtask

  task automatic test_halt();
    in_syscall = 1; in_v0 = 10; in_go = 1;
    tick(); in_syscall = 0;
    checks++; if (out_halted !== 1'b1 || out_pc_en !== 1'b0) begin failures++; $display("FAIL halt_entry got=%b%b exp=10", out_halted, out_pc_en); end
    tick(); tick();
    checks++; if (out_halted !== 1'b1) begin failures++; $display("FAIL halt_held_go got=%b exp=1", out_halted); end
    in_go = 0; tick();
    checks++; if (out_halted !== 1'b1) begin failures++; $display("FAIL halt_release got=%b exp=1", out_halted); end
    in_go = 1; tick();
    checks++; if (out_halted !== 1'b0 || out_pc_en !== 1'b1) begin failures++; $display("FAIL halt_resume got=%b%b exp=01", out_halted, out_pc_en); end
    in_go = 0;
  endtask

  task automatic test_wait_go();
    in_syscall = 1; in_v0 = 50;
    tick(); in_syscall = 0;
    checks++; if (out_pc_en !== 1'b0 || out_halted !== 1'b0) begin failures++; $display("FAIL wait_entry got=%b%b exp=00", out_pc_en, out_halted); end
    tick();
    checks++; if (out_pc_en !== 1'b0) begin failures++; $display("FAIL wait_hold got=%b exp=0", out_pc_en); end
    in_go = 1; tick();
    checks++; if (out_pc_en !== 1'b1) begin failures++; $display("FAIL wait_exit got=%b exp=1", out_pc_en); end
    in_go = 0; in_syscall = 1; in_v0 = 5; in_a0 = 32'h0000_0123;
    tick(); in_syscall = 0;
    checks++; if (out_pc_en !== 1'b1) begin failures++; $display("FAIL noop_pc_en got=%b exp=1", out_pc_en); end
    checks++; if (out_disp !== 32'hDEADBEEF || out_disp_valid !== 1'b0) begin failures++; $display("FAIL noop_disp got=%h/%b exp=deadbeef/0", out_disp, out_disp_valid); end
  endtask

  task automatic test_reset_mid_pause();
    in_instr_valid = 1; in_syscall = 1; in_v0 = 34; in_a0 = 32'h1234_5678;
    tick(); in_syscall = 0;
    tick(); tick();
    in_rst = 1; in_syscall = 1;
    tick(); in_rst = 0; in_syscall = 0;
    checks++; if (out_pc_en !== 1'b1 || out_halted !== 1'b0) begin failures++; $display("FAIL rst_pause_state got=%b%b exp=10", out_pc_en, out_halted); end
    checks++; if (out_disp !== 32'd0 || out_disp_valid !== 1'b0) begin failures++; $display("FAIL rst_pause_disp got=%h/%b exp=0/0", out_disp, out_disp_valid); end
    checks++; if (out_cycles !== 32'd0) begin failures++; $display("FAIL rst_pause_cycles got=%h exp=0", out_cycles); end
    in_instr_valid = 0; tick();
    checks++; if (out_pc_en !== 1'b1) begin failures++; $display("FAIL rst_pause_stays_run got=%b exp=1", out_pc_en); end
  endtask

  task automatic test_wrap();
    in_instr_valid = 0;
`ifdef CYCLE_COUNT_EN
    force dut.cycles_q = 32'hFFFF_FFFF;
    tick();
    release dut.cycles_q;
    checks++; if (out_cycles !== 32'hFFFF_FFFF) begin failures++; $display("FAIL wrap_preload got=%h exp=ffffffff", out_cycles); end
`endif
    in_instr_valid = 1; tick(); in_instr_valid = 0;
    checks++; if (out_cycles !== 32'd0) begin failures++; $display("FAIL wrap_result got=%h exp=0", out_cycles); end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 800; i++) begin
      checks++;
      if (out_pc_en !== (m_stall == 0 && !m_wait && !m_halt) || out_halted !== m_halt ||
          out_disp !== m_disp || out_disp_valid !== m_dv || out_cycles !== m_cyc) begin
        failures++;
        $display("FAIL random cyc=%0d got pc=%b h=%b d=%h dv=%b c=%0d exp pc=%b h=%b d=%h dv=%b c=%0d",
                 i, out_pc_en, out_halted, out_disp, out_disp_valid, out_cycles,
                 m_stall == 0 && !m_wait && !m_halt, m_halt, m_disp, m_dv, m_cyc);
      end
      in_rst = ($urandom % 100) == 0;
      in_instr_valid = ($urandom % 4) != 0;
      in_syscall = ($urandom % 4) == 0;
      case ($urandom % 5)
        0: in_v0 = 10;
        1: in_v0 = 34;
        2: in_v0 = 50;
        3: in_v0 = 5;
        default: in_v0 = $urandom;
      endcase
      in_a0 = $urandom;
      in_go = ($urandom % 3) == 0;
      tick();
    end
    in_rst = 0; in_syscall = 0; in_go = 0;
  endtask

  initial begin
    test_reset();
    test_count();
    test_display();
    test_halt();
    test_wait_go();
    test_reset_mid_pause();
    test_wrap();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
